// File: rtl/alu_operation.sv
// rtl/alu_operation.sv - registered bitwise logic unit (AND/OR/XOR/NOT A) with valid strobe and zero flag
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   A, B       WIDTH-bit operands
//   S0, S1     operation select, op = {S1,S0}: 00 AND, 01 OR, 10 XOR, 11 NOT A
//   in_valid   operands/select are valid this cycle
//   F          registered result
//   out_valid  one-cycle pulse per accepted input
//   zero       registered flag, 1 when F == 0

module alu_operation #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             S0,
    input  logic             S1,
    input  logic             in_valid,
    output logic [WIDTH-1:0] F,
    output logic             out_valid,
    output logic             zero
);

    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] f_d, f_q;
    logic             zero_d, zero_q;
    logic             valid_d, valid_q;

    always_comb begin
        result = '0;
        case ({S1, S0})
            2'b00: result = A & B;
            2'b01: result = A | B;
            2'b10: result = A ^ B;
            2'b11: result = ~A;
            default: result = '0;
        endcase
    end

    // F and zero hold when idle; zero is derived from the same value loaded
    // into F so the two can never disagree.
    always_comb begin
        f_d     = f_q;
        zero_d  = zero_q;
        valid_d = 1'b0;
        if (in_valid) begin
            f_d     = result;
            zero_d  = (result == '0);
            valid_d = 1'b1;
        end
    end

    // Reset wins over a simultaneous in_valid: nothing is captured on that edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            f_q     <= '0;
            zero_q  <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            f_q     <= f_d;
            zero_q  <= zero_d;
            valid_q <= valid_d;
        end
    end

    assign F         = f_q;
    assign zero      = zero_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_alu_operation.sv
// tb/tb_alu_operation.sv - self-checking bench for alu_operation (WIDTH=1 and WIDTH=8 instances)

module tb_alu_operation;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       S0, S1;
    logic       A1, B1;
    logic [7:0] A8, B8;
    logic       F1, out_valid1, zero1;
    logic [7:0] F8;
    logic       out_valid8, zero8;

    always #5 clk = ~clk;

    alu_operation #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .A(A1), .B(B1), .S0(S0), .S1(S1),
        .in_valid(in_valid), .F(F1), .out_valid(out_valid1), .zero(zero1)
    );

    alu_operation #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .A(A8), .B(B8), .S0(S0), .S1(S1),
        .in_valid(in_valid), .F(F8), .out_valid(out_valid8), .zero(zero8)
    );

    int passed = 0;
    int total  = 0;

    // Reference state
    logic       m_f1, m_z1, m_v;
    logic [7:0] m_f8;
    logic       m_z8;

    // Per-bit truth table lookup, indexed by {a,b}
    function automatic logic [7:0] ref_op(input logic [7:0] a, input logic [7:0] b,
                                          input logic [1:0] op, input int w);
        logic [3:0] tbl;
        logic [7:0] r;
        case (op)
            2'd0:    tbl = 4'b1000;
            2'd1:    tbl = 4'b1110;
            2'd2:    tbl = 4'b0110;
            default: tbl = 4'b0011;
        endcase
        r = 8'h00;
        for (int i = 0; i < w; i++) r[i] = tbl[{a[i], b[i]}];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic set_in(input logic r, input logic v, input logic [1:0] op,
                          input logic a1, input logic b1, input logic [7:0] a8, input logic [7:0] b8);
        rst = r; in_valid = v; {S1, S0} = op; A1 = a1; B1 = b1; A8 = a8; B8 = b8;
    endtask

    // Advance one edge, update the model from the inputs seen at that edge, then compare.
    task automatic step(input string tag);
        logic [7:0] r1, r8;
        @(posedge clk);
        r1 = ref_op({7'b0, A1}, {7'b0, B1}, {S1, S0}, 1);
        r8 = ref_op(A8, B8, {S1, S0}, 8);
        if (rst) begin
            m_f1 = 1'b0; m_z1 = 1'b1; m_f8 = 8'h00; m_z8 = 1'b1; m_v = 1'b0;
        end else if (in_valid) begin
            m_f1 = r1[0]; m_z1 = (r1[0] == 1'b0);
            m_f8 = r8;    m_z8 = (r8 == 8'h00);
            m_v  = 1'b1;
        end else begin
            m_v = 1'b0;
        end
        #1;
        chk({tag, ".F1"},  {7'b0, F1},         {7'b0, m_f1});
        chk({tag, ".Z1"},  {7'b0, zero1},      {7'b0, m_z1});
        chk({tag, ".V1"},  {7'b0, out_valid1}, {7'b0, m_v});
        chk({tag, ".F8"},  F8,                 m_f8);
        chk({tag, ".Z8"},  {7'b0, zero8},      {7'b0, m_z8});
        chk({tag, ".V8"},  {7'b0, out_valid8}, {7'b0, m_v});
    endtask

    initial begin
        logic [3:0] tt_and, tt_or, tt_xor, tt_not;
        tt_and = 4'b0001; tt_or = 4'b0111; tt_xor = 4'b0110; tt_not = 4'b1100;

        m_f1 = 1'b0; m_z1 = 1'b1; m_f8 = 8'h00; m_z8 = 1'b1; m_v = 1'b0;

        // Reset for two edges with a valid operation presented
        set_in(1'b1, 1'b1, 2'b00, 1'b1, 1'b1, 8'hFF, 8'hFF);
        step("rst0");
        chk("rst0.const", F8, 8'h00);
        step("rst1");
        chk("rst1.zero", {7'b0, zero1}, 8'h01);

        // Exhaustive WIDTH=1 sweep; listed tables are for AB = 00,01,10,11
        for (int op = 0; op < 4; op++) begin
            for (int ab = 0; ab < 4; ab++) begin
                logic [3:0] tt;
                set_in(1'b0, 1'b1, op[1:0], ab[1], ab[0], 8'($urandom), 8'($urandom));
                step("sweep");
                tt = (op == 0) ? tt_and : (op == 1) ? tt_or : (op == 2) ? tt_xor : tt_not;
                chk("sweep.tbl", {7'b0, F1}, {7'b0, tt[3 - ab]});
            end
        end

        // Hold
        set_in(1'b0, 1'b1, 2'b10, 1'b1, 1'b0, 8'hA5, 8'h0F);
        step("hold0");
        set_in(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 8'h00, 8'h00);
        step("hold1");
        chk("hold.F1", {7'b0, F1}, 8'h01);
        chk("hold.F8", F8, 8'hAA);
        step("hold2");

        // Zero flag
        set_in(1'b0, 1'b1, 2'b10, 1'b1, 1'b1, 8'h5A, 8'h5A);
        step("zf0");
        chk("zf0.z8", {7'b0, zero8}, 8'h01);
        set_in(1'b0, 1'b1, 2'b11, 1'b0, 1'b1, 8'h00, 8'h00);
        step("zf1");
        chk("zf1.F8", F8, 8'hFF);

        // Mid-stream reset
        set_in(1'b0, 1'b1, 2'b00, 1'b1, 1'b1, 8'hC3, 8'hFF);
        step("mid0");
        set_in(1'b1, 1'b1, 2'b00, 1'b1, 1'b1, 8'hC3, 8'hFF);
        step("mid1");
        chk("mid1.V", {7'b0, out_valid8}, 8'h00);

        // WIDTH=8 directed values
        set_in(1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 8'hF0, 8'h3C); step("w8and"); chk("w8and.c", F8, 8'h30);
        set_in(1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 8'hF0, 8'h3C); step("w8or");  chk("w8or.c",  F8, 8'hFC);
        set_in(1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 8'hF0, 8'h3C); step("w8xor"); chk("w8xor.c", F8, 8'hCC);
        set_in(1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 8'hF0, 8'h3C); step("w8not"); chk("w8not.c", F8, 8'h0F);

        // Randomized traffic with occasional reset and idle cycles
        for (int i = 0; i < 300; i++) begin
            logic [7:0] a8, b8;
            a8 = 8'($urandom);
            b8 = ($urandom_range(0, 3) == 0) ? a8 : 8'($urandom);
            set_in($urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0,
                   2'($urandom), 1'($urandom), 1'($urandom), a8, b8);
            step("rand");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
